// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserialiser slice.
// Widths that depend on a module parameter are derived with the helper functions.
package s2p_pkg;

    localparam int S2P_WIDTH = 32'sd8;
    localparam int S2P_DEPTH = 32'sd4;
    localparam int CNT_W     = $clog2(S2P_WIDTH + 32'sd1);
    localparam int LVL_W     = $clog2(S2P_DEPTH + 32'sd1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } s2p_st_e;

    typedef struct packed {
        logic [S2P_WIDTH-1:0] word;
        logic [CNT_W-1:0]     nbits;
        logic                 last;
    } s2p_word_t;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int clog2p1(input int n);
        return $clog2(n + 32'sd1);
    endfunction

endpackage

// File: rtl/s2p_fifo.sv
// Synchronous show-ahead FIFO whose head is held in a register, so the output
// is glitch-free and keeps its last value once the FIFO runs empty.
module s2p_fifo
    import s2p_pkg::*;
#(
    parameter int DW    = 32'sd8,
    parameter int DEPTH = 32'sd4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        push,
    input  logic [DW-1:0]               din,
    input  logic                        pop,
    output logic [DW-1:0]               dout,
    output logic                        vld,
    output logic                        full,
    output logic                        empty,
    output logic [clog2p1(DEPTH)-1:0]   lvl
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = clog2p1(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] lvl_r;
    logic [LW-1:0] lvl_nxt_s;
    logic [DW-1:0] head_r;
    logic [DW-1:0] head_nxt_s;
    logic          vld_r;
    logic          full_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_s    = (lvl_r == LW'(DEPTH));
    assign do_pop_s  = pop & vld_r;
    assign do_push_s = push & (~full_s | do_pop_s);

    // Next head and occupancy; a pop with one entry left hands the head straight to the incoming word.
    always_comb begin
        head_nxt_s = head_r;
        lvl_nxt_s  = lvl_r;
        if (do_pop_s) begin
            if (lvl_r > LW'(1)) begin
                head_nxt_s = mem_r[rd_ptr_r + PW'(1)];
            end else if (do_push_s) begin
                head_nxt_s = din;
            end else begin
                head_nxt_s = head_r;
            end
        end else if (do_push_s && (lvl_r == LW'(0))) begin
            head_nxt_s = din;
        end else begin
            head_nxt_s = head_r;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   lvl_nxt_s = lvl_r + LW'(1);
            2'b01:   lvl_nxt_s = lvl_r - LW'(1);
            default: lvl_nxt_s = lvl_r;
        endcase
    end

    // Storage, pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            lvl_r    <= '0;
            head_r   <= '0;
            vld_r    <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            lvl_r  <= lvl_nxt_s;
            head_r <= head_nxt_s;
            vld_r  <= (lvl_nxt_s != LW'(0));
        end
    end

    assign dout  = head_r;
    assign vld   = vld_r;
    assign full  = full_s;
    assign empty = ~vld_r;
    assign lvl   = lvl_r;

endmodule

// File: rtl/s2p_deser.sv
// Serial-to-parallel deserialiser: bit collection, frame termination with optional
// partial-word flush, and a sticky overflow flag in front of the output FIFO.
module s2p_deser
    import s2p_pkg::*;
#(
    parameter int WIDTH      = 32'sd8,
    parameter int DEPTH      = 32'sd4,
    parameter int MSB_FIRST  = 32'sd1,
    parameter int PART_FLUSH = 32'sd1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        sin_vld,
    input  logic                        sin,
    input  logic                        sin_last,
    output logic                        pout_vld,
    input  logic                        pout_rdy,
    output logic [WIDTH-1:0]            pout,
    output logic [clog2p1(WIDTH)-1:0]   pout_nbits,
    output logic                        pout_last,
    output logic [clog2p1(DEPTH)-1:0]   lvl,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int CW = clog2p1(WIDTH);
    localparam int DW = WIDTH + CW + 32'sd1;
    localparam logic [WIDTH-1:0] ONE_BIT = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic FLUSH_EN = (PART_FLUSH != 32'sd0);
    localparam logic MSB_EN   = (MSB_FIRST != 32'sd0);

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic [CW-1:0]    nbits;
        logic             last;
    } word_t;

    s2p_st_e          st_r;
    s2p_st_e          st_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] word_s;
    logic             at_end_s;
    logic             done_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             fifo_vld_s;
    logic             ovf_r;
    word_t            push_ent_s;
    word_t            head_s;

    // The incoming bit merged into the word at its slot; untouched slots are still zero.
    always_comb begin
        mask_s     = MSB_EN ? (TOP_BIT >> cnt_r) : (ONE_BIT << cnt_r);
        word_s     = sin ? (shreg_r | mask_s) : (shreg_r & ~mask_s);
        at_end_s   = (cnt_r == CW'(WIDTH - 32'sd1));
        done_s     = sin_vld & (at_end_s | sin_last);
        push_s     = sin_vld & (at_end_s | (sin_last & FLUSH_EN));
        push_ent_s = '{word: word_s, nbits: cnt_r + CW'(1), last: sin_last};
    end

    // Collection FSM and bit counter; idle cycles hold everything.
    always_comb begin
        st_nxt_s    = st_r;
        cnt_nxt_s   = cnt_r;
        shreg_nxt_s = shreg_r;
        case (st_r)
            IDLE: begin
                if (sin_vld && !done_s) begin
                    st_nxt_s = COLLECT;
                end else begin
                    st_nxt_s = IDLE;
                end
            end
            COLLECT: begin
                if (done_s) begin
                    st_nxt_s = IDLE;
                end else begin
                    st_nxt_s = COLLECT;
                end
            end
            default: st_nxt_s = IDLE;
        endcase
        if (done_s) begin
            cnt_nxt_s   = '0;
            shreg_nxt_s = '0;
        end else if (sin_vld) begin
            cnt_nxt_s   = cnt_r + CW'(1);
            shreg_nxt_s = word_s;
        end else begin
            cnt_nxt_s   = cnt_r;
            shreg_nxt_s = shreg_r;
        end
    end

    // Collection state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_r    <= IDLE;
            cnt_r   <= '0;
            shreg_r <= '0;
        end else begin
            st_r    <= st_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shreg_r <= shreg_nxt_s;
        end
    end

    assign pop_s = pout_rdy & ~empty_s;

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_r <= 1'b0;
        end else if (push_s && full_s && !pop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    s2p_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_s),
        .din   (push_ent_s),
        .pop   (pop_s),
        .dout  (head_s),
        .vld   (fifo_vld_s),
        .full  (full_s),
        .empty (empty_s),
        .lvl   (lvl)
    );

    assign pout_vld   = fifo_vld_s;
    assign pout       = head_s.word;
    assign pout_nbits = head_s.nbits;
    assign pout_last  = head_s.last;
    assign ovf        = ovf_r;

endmodule
